// File: rtl/sysid_boot_checker.sv
// rtl/sysid_boot_checker.sv - reads sysid ID/timestamp words after boot and flags an image mismatch (option: SYSID_CHECK_TIMEOUT_EN)
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1486319916,
    parameter logic        CHECK_TIMESTAMP    = 1'b1,
    parameter logic        AUTO_START         = 1'b1,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
`ifdef SYSID_CHECK_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_CMP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        read_next;
    logic        address_next;
    logic        done_next;
    logic        pass_next;
    logic [31:0] id_next;
    logic [31:0] ts_next;

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic [7:0] stall_cnt_next;
    logic       timeout_next;
    logic       stall_limit;

    // The current stall cycle is the last one allowed for this read.
    assign stall_limit = (stall_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    // Parameter stays in the interface so both builds share one instantiation.
    logic [7:0] timeout_cycles_unused;
    assign timeout_cycles_unused = 8'(TIMEOUT_CYCLES);
`endif

    // Bus is owned only while one of the two reads or the compare is pending.
    assign busy = (state == S_RD_ID) || (state == S_RD_TS) || (state == S_CMP);

    // Next-state, capture and flag logic; bus strobes are derived from the next state
    // so they come straight out of flops and stay put while the slave stalls.
    always_comb begin
        state_next = state;
        done_next  = done;
        pass_next  = pass;
        id_next    = id_value;
        ts_next    = ts_value;
`ifdef SYSID_CHECK_TIMEOUT_EN
        stall_cnt_next = stall_cnt;
        timeout_next   = timeout;
`endif
        case (state)
            S_IDLE: begin
                if (AUTO_START || start) begin
                    state_next = S_RD_ID;
                end
            end
            S_RD_ID: begin
                if (!avm_waitrequest) begin
                    id_next    = avm_readdata;
                    state_next = S_RD_TS;
`ifdef SYSID_CHECK_TIMEOUT_EN
                    stall_cnt_next = 8'd0;
`endif
                end
`ifdef SYSID_CHECK_TIMEOUT_EN
                else if (stall_limit) begin
                    state_next     = S_DONE;
                    done_next      = 1'b1;
                    pass_next      = 1'b0;
                    timeout_next   = 1'b1;
                    stall_cnt_next = 8'd0;
                end else begin
                    stall_cnt_next = stall_cnt + 8'd1;
                end
`endif
            end
            S_RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_next    = avm_readdata;
                    state_next = S_CMP;
`ifdef SYSID_CHECK_TIMEOUT_EN
                    stall_cnt_next = 8'd0;
`endif
                end
`ifdef SYSID_CHECK_TIMEOUT_EN
                else if (stall_limit) begin
                    state_next     = S_DONE;
                    done_next      = 1'b1;
                    pass_next      = 1'b0;
                    timeout_next   = 1'b1;
                    stall_cnt_next = 8'd0;
                end else begin
                    stall_cnt_next = stall_cnt + 8'd1;
                end
`endif
            end
            S_CMP: begin
                pass_next  = (id_value == EXPECTED_ID) &&
                             (!CHECK_TIMESTAMP || (ts_value == EXPECTED_TIMESTAMP));
                done_next  = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_next = S_RD_ID;
                    done_next  = 1'b0;
                    pass_next  = 1'b0;
`ifdef SYSID_CHECK_TIMEOUT_EN
                    timeout_next = 1'b0;
`endif
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        read_next    = (state_next == S_RD_ID) || (state_next == S_RD_TS);
        address_next = (state_next == S_RD_TS);
    end

    // State, bus strobes, captured words and sticky flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
`ifdef SYSID_CHECK_TIMEOUT_EN
            stall_cnt   <= 8'd0;
            timeout     <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            avm_read    <= read_next;
            avm_address <= address_next;
            done        <= done_next;
            pass        <= pass_next;
            id_value    <= id_next;
            ts_value    <= ts_next;
`ifdef SYSID_CHECK_TIMEOUT_EN
            stall_cnt   <= stall_cnt_next;
            timeout     <= timeout_next;
`endif
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb/tb_sysid_boot_checker.sv - randomized bench with a transaction-level check model for sysid_boot_checker
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1486319916;
    localparam int          TO_A   = 8;
`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam logic        TO_EN  = 1'b1;
`else
    localparam logic        TO_EN  = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        waitreq = 1'b0;
    logic [31:0] slave_id = EXP_ID;
    logic [31:0] slave_ts = EXP_TS;

    logic        a_read, a_addr, a_busy, a_done, a_pass;
    logic [31:0] a_id, a_ts, a_rdata;
    logic        b_read, b_addr, b_busy, b_done, b_pass;
    logic [31:0] b_id, b_ts, b_rdata;
    logic        a_timeout, b_timeout;

    assign a_rdata = a_addr ? slave_ts : slave_id;
    assign b_rdata = b_addr ? slave_ts : slave_id;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // dut_a: auto start, full check; dut_b: start-only, timestamp captured but not checked.
    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .CHECK_TIMESTAMP(1'b1),
        .AUTO_START(1'b1), .TIMEOUT_CYCLES(TO_A)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(waitreq),
        .avm_readdata(a_rdata), .busy(a_busy), .done(a_done), .pass(a_pass),
        .id_value(a_id), .ts_value(a_ts)
`ifdef SYSID_CHECK_TIMEOUT_EN
        , .timeout(a_timeout)
`endif
    );

    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .CHECK_TIMESTAMP(1'b0),
        .AUTO_START(1'b0), .TIMEOUT_CYCLES(255)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(waitreq),
        .avm_readdata(b_rdata), .busy(b_busy), .done(b_done), .pass(b_pass),
        .id_value(b_id), .ts_value(b_ts)
`ifdef SYSID_CHECK_TIMEOUT_EN
        , .timeout(b_timeout)
`endif
    );

`ifndef SYSID_CHECK_TIMEOUT_EN
    assign a_timeout = 1'b0;
    assign b_timeout = 1'b0;
`endif

    always #5 clock = ~clock;

    // phase: 0 waiting, 1 reading ID, 2 reading timestamp, 3 comparing, 4 finished
    typedef struct {
        int          phase;
        int          stalls;
        logic [31:0] id;
        logic [31:0] ts;
        logic        done;
        logic        pass;
        logic        tout;
    } mstate_t;

    mstate_t ma, mb;

    function automatic mstate_t fresh();
        mstate_t s;
        s.phase = 0; s.stalls = 0; s.id = 0; s.ts = 0;
        s.done = 0; s.pass = 0; s.tout = 0;
        return s;
    endfunction

    function automatic mstate_t step(mstate_t s, logic st, logic wr, logic [31:0] sid,
                                     logic [31:0] sts, logic auto_s, logic chk_ts, int lim);
        mstate_t n = s;
        case (s.phase)
            0: if (auto_s || st) n.phase = 1;
            1, 2: begin
                if (!wr) begin
                    if (s.phase == 1) n.id = sid;
                    else n.ts = sts;
                    n.phase  = s.phase + 1;
                    n.stalls = 0;
                end else if (TO_EN) begin
                    n.stalls = s.stalls + 1;
                    if (n.stalls >= lim) begin
                        n.phase = 4; n.done = 1; n.pass = 0; n.tout = 1; n.stalls = 0;
                    end
                end
            end
            3: begin
                n.pass  = (s.id == EXP_ID) && (!chk_ts || s.ts == EXP_TS);
                n.done  = 1;
                n.phase = 4;
            end
            default: if (st) begin
                n.phase = 1; n.done = 0; n.pass = 0; n.tout = 0;
            end
        endcase
        return n;
    endfunction

    // Reference model advances on the same edges as the design.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ma  <= fresh();
            mb  <= fresh();
            cyc <= 0;
        end else begin
            ma  <= step(ma, start, waitreq, slave_id, slave_ts, 1'b1, 1'b1, TO_A);
            mb  <= step(mb, start, waitreq, slave_id, slave_ts, 1'b0, 1'b0, 255);
            cyc <= cyc + 1;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Every-cycle comparison of both designs against the model.
    always @(negedge clock) begin
        check32("a.read", a_read, ma.phase == 1 || ma.phase == 2);
        check32("a.addr", a_addr, ma.phase == 2);
        check32("a.busy", a_busy, ma.phase >= 1 && ma.phase <= 3);
        check32("a.done", a_done, ma.done);
        check32("a.pass", a_pass, ma.pass);
        check32("a.id",   a_id,   ma.id);
        check32("a.ts",   a_ts,   ma.ts);
        check32("a.timeout", a_timeout, ma.tout);
        check32("b.read", b_read, mb.phase == 1 || mb.phase == 2);
        check32("b.addr", b_addr, mb.phase == 2);
        check32("b.busy", b_busy, mb.phase >= 1 && mb.phase <= 3);
        check32("b.done", b_done, mb.done);
        check32("b.pass", b_pass, mb.pass);
        check32("b.id",   b_id,   mb.id);
        check32("b.ts",   b_ts,   mb.ts);
        check32("b.timeout", b_timeout, mb.tout);
    end

    task automatic do_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int first;
        repeat (3) @(negedge clock);
        check32("reset.read", a_read, 1'b0);
        check32("reset.done", a_done, 1'b0);
        check32("reset.id", a_id, 32'd0);
        #2 reset_n = 1'b1;

        // Good image, no stall: done/pass appear in cycle 4 after release.
        repeat (3) @(negedge clock);
        check32("t1.done_c3", a_done, 1'b0);
        @(negedge clock);
        check32("t1.cyc", cyc, 4);
        check32("t1.done_c4", a_done, 1'b1);
        check32("t1.pass_c4", a_pass, 1'b1);
        check32("t1.b_idle", b_busy, 1'b0);

        // Five stall cycles on each read: done first seen in cycle 14.
        do_reset();
        first = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            waitreq = (cyc >= 1 && cyc <= 5) || (cyc >= 7 && cyc <= 11);
            if (a_done && first < 0) first = cyc;
        end
        waitreq = 1'b0;
        check32("t2.done_cycle", first, 14);
        check32("t2.pass", a_pass, 1'b1);
        check32("t2.ts", a_ts, EXP_TS);

        // Wrong ID word.
        slave_id = 32'h0000_0001;
        do_reset();
        repeat (6) @(negedge clock);
        check32("t3.id", a_id, 32'h0000_0001);
        check32("t3.done", a_done, 1'b1);
        check32("t3.pass", a_pass, 1'b0);

        // Bad timestamp, restart from DONE; dut_b ignores the timestamp.
        slave_id = EXP_ID;
        slave_ts = 32'hDEAD_BEEF;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check32("t4.done_clear", a_done, 1'b0);
        check32("t4.busy", a_busy, 1'b1);
        repeat (3) @(negedge clock);
        check32("t4.a_done", a_done, 1'b1);
        check32("t4.a_pass", a_pass, 1'b0);
        check32("t4.a_ts", a_ts, 32'hDEAD_BEEF);
        check32("t4.b_done", b_done, 1'b1);
        check32("t4.b_pass", b_pass, 1'b1);

        // Start during the timestamp read is ignored.
        slave_ts = EXP_TS;
        do_reset();
        repeat (2) @(negedge clock);
        check32("t5.addr", a_addr, 1'b1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check32("t5.done", a_done, 1'b1);
        check32("t5.no_restart", a_busy, 1'b0);

        // Reset while the ID read is stalled.
        do_reset();
        waitreq = 1'b1;
        repeat (2) @(negedge clock);
        check32("t6.read_before", a_read, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check32("t6.read_async", a_read, 1'b0);
        check32("t6.busy_async", a_busy, 1'b0);
        @(negedge clock);
        waitreq = 1'b0;
        #2 reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check32("t6.rerun_done", a_done, 1'b1);

`ifdef SYSID_CHECK_TIMEOUT_EN
        // Slave stuck in wait: timeout after TO_A stall cycles.
        do_reset();
        waitreq = 1'b1;
        first = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (a_timeout && first < 0) first = cyc;
        end
        waitreq = 1'b0;
        check32("t7.timeout_cycle", first, TO_A + 1);
        check32("t7.done", a_done, 1'b1);
        check32("t7.pass", a_pass, 1'b0);
        check32("t7.read", a_read, 1'b0);
`endif

        // Randomized traffic; the every-cycle compare does the checking.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            waitreq = ($urandom_range(99) < 30);
            start   = !start && ($urandom_range(99) < 8);
            if ($urandom_range(39) == 0) slave_id = $urandom_range(1) ? EXP_ID : $urandom;
            if ($urandom_range(39) == 0) slave_ts = $urandom_range(1) ? EXP_TS : $urandom;
            if ($urandom_range(399) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clock);
                #2 reset_n = 1'b1;
            end
        end
        start = 1'b0;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
